fir_mac_sequencer: RTL and testbench
====================================

Name: fir_mac_sequencer

Overview:
- Sequencer for a time-shared, single-MAC FIR filter fed by the 12-bit DDS sample stream.
- Generates the sample-rate tick from CLOCK itself, replacing a derived slow clock.
- For each tick it captures one sample, writes it into a circular delay-line RAM, then drives TAPS address/enable pairs into the MAC and flags the result.
- Also arbitrates coefficient-RAM updates against filtering.

Parameters:
- DIV_N, 25000: CLOCK cycles per sample tick (50 MHz -> 2 kHz). Must be >= TAPS+MAC_LAT+4.
- TAPS, 16: filter length, power of two.
- AW, 4: address width, log2(TAPS).
- MAC_LAT, 2: cycles from mac_en to accumulator update in the external MAC.

Ports:
- CLOCK  in  1  system clock.
- RESET  in  1  asynchronous, active-low reset.
- xin  in  12  DDS sample, sampled on the tick cycle.
- coef_upd_req  in  1  host requests coefficient-RAM access.
- coef_upd_gnt  out  1  host owns coefficient RAM while high.
- dl_we  out  1  delay-line write enable.
- dl_waddr  out  AW  delay-line write address.
- dl_wdata  out  12  delay-line write data.
- dl_raddr  out  AW  delay-line read address.
- coef_raddr  out  AW  coefficient read address.
- mac_clr  out  1  clear accumulator with this product.
- mac_en  out  1  accumulate this product.
- y_valid  out  1  1-cycle strobe: accumulator holds the new output.
- busy  out  1  sequence in progress.
- overrun  out  1  sticky: a tick was lost.

Behaviour:
- Reset: all outputs 0. Divider = 0, wptr = 0, pending = 0, state = IDLE.
- Divider:
  - Counts 0..DIV_N-1 and wraps.
  - tick = 1 on the cycle it wraps to 0, so the first tick arrives DIV_N cycles after reset release.
- FSM states: IDLE, WRITE, RUN, DRAIN, DONE.
- IDLE:
  - Start condition: (tick or pending) and coef_upd_gnt=0.
  - On start: latch xin (on a pending start, the value latched when the tick arrived); clear pending; go to WRITE.
  - Grant condition: coef_upd_req=1, no start, no tick this cycle.
  - On grant: coef_upd_gnt=1 next cycle, held until req drops.
  - gnt deasserts the cycle after req falls.
- WRITE (1 cycle): dl_we=1, dl_waddr=wptr, dl_wdata=latched sample; go to RUN with k=0.
- RUN (TAPS cycles):
  - mac_en=1, coef_raddr=k, dl_raddr=(wptr-k) mod TAPS.
  - mac_clr=1 only when k=0.
  - After k=TAPS-1, go to DRAIN.
- DRAIN: MAC_LAT cycles with mac_en=0; then go to DONE.
- DONE (1 cycle): y_valid=1, wptr <= wptr+1 (wraps TAPS-1 -> 0); return to IDLE.
- busy=1 in every state except IDLE.
- Latency: tick to y_valid = TAPS+MAC_LAT+2 cycles (18+2 = 20 with defaults).
- Tick while busy or while gnt=1:
  - If pending=0: set pending and latch xin.
  - If pending=1: set overrun, drop the tick, keep the first pending sample.
- Tick on the same cycle the FSM returns to IDLE from DONE: treated as a start from IDLE, not as pending.
- Tick and req rising together in IDLE: the tick wins; req waits until the next IDLE cycle.
- overrun clears only on reset.
- Reset asserted mid-sequence: immediate return to reset state. Outputs go to 0 asynchronously; no y_valid is emitted.

Test Plan:
- Reset release, xin=12'h123 held, DIV_N=40:
  - tick at cycle 40; dl_we at 41 with addr 0, data 12'h123.
  - mac_en at 42..57, mac_clr only at 42.
  - y_valid at 60.
- Address sweep on the third sample (wptr=2):
  - dl_raddr sequence 2,1,0,15,14,...,3.
  - coef_raddr sequence 0..15.
  - After DONE, wptr=3.
- coef_upd_req raised at cycle 5, held to cycle 70, DIV_N=40:
  - gnt=1 from 6 to 71.
  - Tick at 40 goes pending; dl_we at 72 with the xin value from cycle 40.
  - overrun stays 0.
- Same as above, but req held to cycle 100:
  - Second tick at 80 sets overrun=1.
  - Only one sample is processed after gnt drops.
- Tick and req both rising in the same IDLE cycle: sequence starts; gnt rises the cycle after DONE.
- RESET pulsed low during RUN at k=7:
  - mac_en=0 immediately; y_valid never pulses.
  - Next tick comes DIV_N cycles after release and writes to address 0.

Source files
------------

// File: rtl/fir_mac_sequencer.sv
// fir_mac_sequencer
// Control sequencer for a time-shared, single-MAC FIR filter fed by a 12-bit
// DDS sample stream. A free-running divider produces a one-cycle sample tick
// from CLOCK. Each tick captures one sample and writes it into a circular
// delay-line RAM. The sequencer then walks TAPS coefficient/delay-line address
// pairs into the external MAC, waits out the MAC pipeline, and strobes y_valid.
// Host access to the coefficient RAM is granted only while the filter is idle.
//
// Ports:
//   CLOCK         system clock
//   RESET         asynchronous, active-low reset
//   xin           DDS sample, captured on the tick cycle
//   coef_upd_req  host request for coefficient-RAM ownership
//   coef_upd_gnt  host owns the coefficient RAM while high
//   dl_we         delay-line write enable
//   dl_waddr      delay-line write address
//   dl_wdata      delay-line write data
//   dl_raddr      delay-line read address, newest sample first
//   coef_raddr    coefficient read address
//   mac_clr       start a new accumulation with this product
//   mac_en        accumulate this product
//   y_valid       one-cycle strobe: the accumulator holds the new output
//   busy          a filter sequence is in progress
//   overrun       sticky flag: a sample tick was lost
// Every output is registered.
module fir_mac_sequencer #(
    parameter int DIV_N   = 25000,
    parameter int TAPS    = 16,
    parameter int AW      = 4,
    parameter int MAC_LAT = 2
) (
    input  logic          CLOCK,
    input  logic          RESET,
    input  logic [11:0]   xin,
    input  logic          coef_upd_req,
    output logic          coef_upd_gnt,
    output logic          dl_we,
    output logic [AW-1:0] dl_waddr,
    output logic [11:0]   dl_wdata,
    output logic [AW-1:0] dl_raddr,
    output logic [AW-1:0] coef_raddr,
    output logic          mac_clr,
    output logic          mac_en,
    output logic          y_valid,
    output logic          busy,
    output logic          overrun
);

    localparam int DIVW = (DIV_N > 1) ? $clog2(DIV_N) : 1;
    localparam int DRW  = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WRITE = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t          state_r, state_s;
    logic [DIVW-1:0] div_r;
    logic            tick_r;
    logic [AW-1:0]   k_r, k_s;
    logic [DRW-1:0]  drain_r, drain_s;
    logic [AW-1:0]   wptr_r, wptr_s;
    logic            pending_r, pending_s;
    logic [11:0]     pend_smp_r, pend_smp_s;
    logic            overrun_s, gnt_s;
    logic            we_s, clr_s, en_s, yv_s;
    logic [AW-1:0]   waddr_s, raddr_s, craddr_s;
    logic [11:0]     wdata_s;
    logic            gnt_hold_s, start_s, tick_used_s;

    // Sample-rate divider: tick_r is high for the one cycle in which div_r wraps to 0.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            div_r  <= {DIVW{1'b0}};
            tick_r <= 1'b0;
        end else begin
            if (div_r == DIVW'(DIV_N - 1)) begin
                div_r <= {DIVW{1'b0}};
            end else begin
                div_r <= div_r + DIVW'(1);
            end
            tick_r <= (div_r == DIVW'(DIV_N - 1));
        end
    end

    // Next state, bookkeeping and next-cycle output values.
    // Outputs are decoded from the state being entered so that they can be registered.
    always_comb begin
        state_s    = state_r;
        k_s        = k_r;
        drain_s    = drain_r;
        wptr_s     = wptr_r;
        pending_s  = pending_r;
        pend_smp_s = pend_smp_r;
        overrun_s  = overrun;
        gnt_s      = coef_upd_gnt;
        we_s       = 1'b0;
        waddr_s    = {AW{1'b0}};
        wdata_s    = 12'h000;
        raddr_s    = {AW{1'b0}};
        craddr_s   = {AW{1'b0}};
        clr_s      = 1'b0;
        en_s       = 1'b0;
        yv_s       = 1'b0;

        // The host keeps the coefficient RAM only while req stays high; once req
        // drops, the grant is already being released, so a start may go ahead.
        gnt_hold_s  = coef_upd_gnt & coef_upd_req;
        start_s     = (state_r == ST_IDLE) && (tick_r || pending_r) && !gnt_hold_s;
        // A pending start uses the stored sample, leaving any concurrent tick unconsumed.
        tick_used_s = start_s && !pending_r;

        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_s   = ST_WRITE;
                    pending_s = 1'b0;
                    we_s      = 1'b1;
                    waddr_s   = wptr_r;
                    wdata_s   = pending_r ? pend_smp_r : xin;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_WRITE: begin
                state_s  = ST_RUN;
                k_s      = {AW{1'b0}};
                en_s     = 1'b1;
                clr_s    = 1'b1;
                craddr_s = {AW{1'b0}};
                raddr_s  = wptr_r;
            end
            ST_RUN: begin
                if (k_r == AW'(TAPS - 1)) begin
                    state_s = ST_DRAIN;
                    drain_s = {DRW{1'b0}};
                end else begin
                    k_s      = k_r + AW'(1);
                    en_s     = 1'b1;
                    craddr_s = k_s;
                    // TAPS is a power of two, so the AW-bit subtraction wraps the delay line.
                    raddr_s  = wptr_r - k_s;
                end
            end
            ST_DRAIN: begin
                if (drain_r == DRW'(MAC_LAT - 1)) begin
                    state_s = ST_DONE;
                    yv_s    = 1'b1;
                end else begin
                    drain_s = drain_r + DRW'(1);
                end
            end
            ST_DONE: begin
                state_s = ST_IDLE;
                wptr_s  = wptr_r + AW'(1);
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase

        // A tick that did not start a sequence is parked; a second one is lost.
        if (tick_r && !tick_used_s) begin
            if (pending_r && !start_s) begin
                overrun_s = 1'b1;
            end else begin
                pending_s  = 1'b1;
                pend_smp_s = xin;
            end
        end else begin
            pend_smp_s = pend_smp_s;
        end

        // Grant is only issued from a quiet IDLE cycle; it is then held until req drops.
        if (coef_upd_gnt) begin
            gnt_s = coef_upd_req;
        end else if ((state_r == ST_IDLE) && coef_upd_req && !start_s && !tick_r) begin
            gnt_s = 1'b1;
        end else begin
            gnt_s = 1'b0;
        end
    end

    // State, counters, pending sample and registered outputs.
    always_ff @(posedge CLOCK or negedge RESET) begin
        if (!RESET) begin
            state_r      <= ST_IDLE;
            k_r          <= {AW{1'b0}};
            drain_r      <= {DRW{1'b0}};
            wptr_r       <= {AW{1'b0}};
            pending_r    <= 1'b0;
            pend_smp_r   <= 12'h000;
            overrun      <= 1'b0;
            coef_upd_gnt <= 1'b0;
            dl_we        <= 1'b0;
            dl_waddr     <= {AW{1'b0}};
            dl_wdata     <= 12'h000;
            dl_raddr     <= {AW{1'b0}};
            coef_raddr   <= {AW{1'b0}};
            mac_clr      <= 1'b0;
            mac_en       <= 1'b0;
            y_valid      <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state_r      <= state_s;
            k_r          <= k_s;
            drain_r      <= drain_s;
            wptr_r       <= wptr_s;
            pending_r    <= pending_s;
            pend_smp_r   <= pend_smp_s;
            overrun      <= overrun_s;
            coef_upd_gnt <= gnt_s;
            dl_we        <= we_s;
            dl_waddr     <= waddr_s;
            dl_wdata     <= wdata_s;
            dl_raddr     <= raddr_s;
            coef_raddr   <= craddr_s;
            mac_clr      <= clr_s;
            mac_en       <= en_s;
            y_valid      <= yv_s;
            busy         <= (state_s != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_fir_mac_sequencer.sv
// Directed bench for fir_mac_sequencer with DIV_N=40.
// Cycle n is the interval after the n-th rising edge following reset release
// (cycle 0 is the interval in which RESET rises). Inputs are changed and
// outputs are sampled on falling edges.
module tb_fir_mac_sequencer;

    localparam int DIV_N   = 40;
    localparam int TAPS    = 16;
    localparam int AW      = 4;
    localparam int MAC_LAT = 2;

    logic          CLOCK = 1'b0;
    logic          RESET = 1'b0;
    logic [11:0]   xin = 12'h000;
    logic          coef_upd_req = 1'b0;
    logic          coef_upd_gnt;
    logic          dl_we;
    logic [AW-1:0] dl_waddr;
    logic [11:0]   dl_wdata;
    logic [AW-1:0] dl_raddr;
    logic [AW-1:0] coef_raddr;
    logic          mac_clr;
    logic          mac_en;
    logic          y_valid;
    logic          busy;
    logic          overrun;
    logic [30:0]   all_out;

    int cyc   = 0;
    int tests = 0;
    int fails = 0;

    fir_mac_sequencer #(
        .DIV_N(DIV_N), .TAPS(TAPS), .AW(AW), .MAC_LAT(MAC_LAT)
    ) dut (
        .CLOCK(CLOCK), .RESET(RESET), .xin(xin), .coef_upd_req(coef_upd_req),
        .coef_upd_gnt(coef_upd_gnt), .dl_we(dl_we), .dl_waddr(dl_waddr),
        .dl_wdata(dl_wdata), .dl_raddr(dl_raddr), .coef_raddr(coef_raddr),
        .mac_clr(mac_clr), .mac_en(mac_en), .y_valid(y_valid), .busy(busy),
        .overrun(overrun)
    );

    assign all_out = {coef_upd_gnt, dl_we, dl_waddr, dl_wdata, dl_raddr, coef_raddr,
                      mac_clr, mac_en, y_valid, busy, overrun};

    always #5 CLOCK = ~CLOCK;

    // Advance to the falling edge inside cycle n.
    task automatic goto(input int n);
        while (cyc < n) begin
            @(posedge CLOCK);
            cyc++;
            @(negedge CLOCK);
        end
    endtask

    task automatic do_reset(input logic [11:0] x);
        RESET = 1'b0;
        coef_upd_req = 1'b0;
        xin = x;
        repeat (2) @(posedge CLOCK);
        @(negedge CLOCK);
        RESET = 1'b1;
        cyc = 0;
    endtask

    task automatic test_reset;
        RESET = 1'b0;
        xin = 12'h123;
        repeat (3) @(posedge CLOCK);
        @(negedge CLOCK);
        tests++;
        if (all_out !== 31'd0) begin
            fails++;
            $display("FAIL reset_outputs got=%h exp=%h", all_out, 31'd0);
        end
        RESET = 1'b1;
        cyc = 0;
        tests++;
        if (all_out !== 31'd0) begin
            fails++;
            $display("FAIL release_outputs got=%h exp=%h", all_out, 31'd0);
        end
    endtask

    // First sample after release: xin=123, tick 40, write 41, MAC 42..57, y_valid 60.
    task automatic test_basic;
        logic [4:0] e_ctl;
        logic [3:0] ek;
        logic [3:0] er;
        for (int c = 1; c <= 62; c++) begin
            goto(c);
            e_ctl = {(c == 41), (c >= 42 && c <= 57), (c == 42), (c == 60), (c >= 41 && c <= 60)};
            tests++;
            if ({dl_we, mac_en, mac_clr, y_valid, busy} !== e_ctl) begin
                fails++;
                $display("FAIL basic_ctl cyc=%0d got=%b exp=%b", c,
                         {dl_we, mac_en, mac_clr, y_valid, busy}, e_ctl);
            end
            if (c == 41) begin
                tests++;
                if ({dl_waddr, dl_wdata} !== {4'd0, 12'h123}) begin
                    fails++;
                    $display("FAIL basic_write got=%h exp=%h", {dl_waddr, dl_wdata}, {4'd0, 12'h123});
                end
            end
            if (c >= 42 && c <= 57) begin
                ek = 4'(c - 42);
                er = 4'd0 - ek;
                tests++;
                if ({coef_raddr, dl_raddr} !== {ek, er}) begin
                    fails++;
                    $display("FAIL basic_addr cyc=%0d got=%h exp=%h", c, {coef_raddr, dl_raddr}, {ek, er});
                end
            end
        end
    endtask

    // Samples 2 and 3 continue from test_basic; the third one runs with wptr=2.
    task automatic test_sweep;
        logic [3:0] ek;
        logic [3:0] er;
        goto(70);
        xin = 12'h456;
        goto(81);
        tests++;
        if ({dl_we, dl_waddr, dl_wdata} !== {1'b1, 4'd1, 12'h456}) begin
            fails++;
            $display("FAIL sweep_write2 got=%h exp=%h", {dl_we, dl_waddr, dl_wdata}, {1'b1, 4'd1, 12'h456});
        end
        goto(100);
        xin = 12'h789;
        goto(121);
        tests++;
        if ({dl_we, dl_waddr, dl_wdata} !== {1'b1, 4'd2, 12'h789}) begin
            fails++;
            $display("FAIL sweep_write3 got=%h exp=%h", {dl_we, dl_waddr, dl_wdata}, {1'b1, 4'd2, 12'h789});
        end
        for (int c = 122; c <= 137; c++) begin
            goto(c);
            ek = 4'(c - 122);
            er = 4'd2 - ek;
            tests++;
            if ({mac_en, coef_raddr, dl_raddr} !== {1'b1, ek, er}) begin
                fails++;
                $display("FAIL sweep_addr cyc=%0d got=%h exp=%h", c, {mac_en, coef_raddr, dl_raddr}, {1'b1, ek, er});
            end
        end
        goto(140);
        tests++;
        if (y_valid !== 1'b1) begin
            fails++;
            $display("FAIL sweep_yvalid got=%b exp=1", y_valid);
        end
        goto(161);
        tests++;
        if ({dl_we, dl_waddr} !== {1'b1, 4'd3}) begin
            fails++;
            $display("FAIL sweep_wptr3 got=%h exp=%h", {dl_we, dl_waddr}, {1'b1, 4'd3});
        end
    endtask

    // Host holds the coefficient RAM from 5 to 70; tick 40 is deferred until release.
    task automatic test_grant;
        do_reset(12'hA0A);
        goto(5);
        tests++;
        if (coef_upd_gnt !== 1'b0) begin
            fails++;
            $display("FAIL grant_before got=%b exp=0", coef_upd_gnt);
        end
        coef_upd_req = 1'b1;
        for (int c = 6; c <= 71; c++) begin
            goto(c);
            tests++;
            if ({coef_upd_gnt, dl_we, busy} !== 3'b100) begin
                fails++;
                $display("FAIL grant_hold cyc=%0d got=%b exp=100", c, {coef_upd_gnt, dl_we, busy});
            end
            if (c == 40) xin = 12'h2B3;
            if (c == 41) xin = 12'h777;
        end
        coef_upd_req = 1'b0;
        goto(72);
        tests++;
        if ({coef_upd_gnt, dl_we, dl_waddr, dl_wdata} !== {1'b0, 1'b1, 4'd0, 12'h2B3}) begin
            fails++;
            $display("FAIL grant_release got=%h exp=%h", {coef_upd_gnt, dl_we, dl_waddr, dl_wdata},
                     {1'b0, 1'b1, 4'd0, 12'h2B3});
        end
        goto(91);
        tests++;
        if (y_valid !== 1'b1) begin
            fails++;
            $display("FAIL grant_yvalid got=%b exp=1", y_valid);
        end
        goto(93);
        tests++;
        if ({dl_we, dl_waddr, dl_wdata} !== {1'b1, 4'd1, 12'h777}) begin
            fails++;
            $display("FAIL grant_pending2 got=%h exp=%h", {dl_we, dl_waddr, dl_wdata}, {1'b1, 4'd1, 12'h777});
        end
        goto(95);
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL grant_no_overrun got=%b exp=0", overrun);
        end
    endtask

    // Host holds the RAM until 100, so tick 80 is lost and overrun sets.
    task automatic test_overrun;
        int writes;
        do_reset(12'h111);
        goto(5);
        coef_upd_req = 1'b1;
        goto(41);
        xin = 12'h222;
        goto(80);
        tests++;
        if (overrun !== 1'b0) begin
            fails++;
            $display("FAIL ovr_before got=%b exp=0", overrun);
        end
        goto(81);
        tests++;
        if (overrun !== 1'b1) begin
            fails++;
            $display("FAIL ovr_set got=%b exp=1", overrun);
        end
        goto(101);
        coef_upd_req = 1'b0;
        writes = 0;
        for (int c = 102; c <= 122; c++) begin
            goto(c);
            if (dl_we === 1'b1) writes++;
            if (c == 102) begin
                tests++;
                if ({dl_we, dl_wdata} !== {1'b1, 12'h111}) begin
                    fails++;
                    $display("FAIL ovr_first_sample got=%h exp=%h", {dl_we, dl_wdata}, {1'b1, 12'h111});
                end
            end
        end
        tests++;
        if (writes != 1) begin
            fails++;
            $display("FAIL ovr_one_sample got=%0d exp=1", writes);
        end
        goto(130);
        tests++;
        if ({overrun, coef_upd_gnt} !== 2'b10) begin
            fails++;
            $display("FAIL ovr_sticky got=%b exp=10", {overrun, coef_upd_gnt});
        end
    endtask

    // Tick and req rise together in IDLE: the filter runs first, grant follows.
    task automatic test_tick_req;
        do_reset(12'h321);
        goto(40);
        coef_upd_req = 1'b1;
        for (int c = 41; c <= 61; c++) begin
            goto(c);
            tests++;
            if ({coef_upd_gnt, dl_we, y_valid} !== {1'b0, (c == 41), (c == 60)}) begin
                fails++;
                $display("FAIL tickreq_seq cyc=%0d got=%b exp=%b", c, {coef_upd_gnt, dl_we, y_valid},
                         {1'b0, (c == 41), (c == 60)});
            end
        end
        goto(62);
        tests++;
        if (coef_upd_gnt !== 1'b1) begin
            fails++;
            $display("FAIL tickreq_gnt got=%b exp=1", coef_upd_gnt);
        end
        coef_upd_req = 1'b0;
        goto(63);
        tests++;
        if (coef_upd_gnt !== 1'b0) begin
            fails++;
            $display("FAIL tickreq_gnt_drop got=%b exp=0", coef_upd_gnt);
        end
    endtask

    // Reset during the second sequence at k=7; the next sample writes address 0 again.
    task automatic test_reset_mid;
        do_reset(12'h0F0);
        goto(89);
        tests++;
        if ({mac_en, coef_raddr, dl_raddr} !== {1'b1, 4'd7, 4'd10}) begin
            fails++;
            $display("FAIL mid_k7 got=%h exp=%h", {mac_en, coef_raddr, dl_raddr}, {1'b1, 4'd7, 4'd10});
        end
        RESET = 1'b0;
        #1;
        tests++;
        if (all_out !== 31'd0) begin
            fails++;
            $display("FAIL mid_async_clear got=%h exp=%h", all_out, 31'd0);
        end
        repeat (3) begin
            @(posedge CLOCK);
            @(negedge CLOCK);
            tests++;
            if (all_out !== 31'd0) begin
                fails++;
                $display("FAIL mid_held got=%h exp=%h", all_out, 31'd0);
            end
        end
        RESET = 1'b1;
        cyc = 0;
        for (int c = 1; c <= 41; c++) begin
            goto(c);
            if (c < 41) begin
                tests++;
                if ({y_valid, dl_we, busy} !== 3'b000) begin
                    fails++;
                    $display("FAIL mid_quiet cyc=%0d got=%b exp=000", c, {y_valid, dl_we, busy});
                end
            end else begin
                tests++;
                if ({dl_we, dl_waddr, dl_wdata} !== {1'b1, 4'd0, 12'h0F0}) begin
                    fails++;
                    $display("FAIL mid_restart got=%h exp=%h", {dl_we, dl_waddr, dl_wdata},
                             {1'b1, 4'd0, 12'h0F0});
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_sweep();
        test_grant();
        test_overrun();
        test_tick_req();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
